centroid_accum: RTL and testbench

- Producer end of the weighted-centroid interface.
- Accepts a stream of weighted points (x, y, w), one per handshake.
- Multiply-accumulates them into sumxw, sumyw and sumw, then presents the three sums, held stable, to the centroid divider through a valid/ready handshake.
- Sits between the point source and the centre/rounding stage. Each frame of N_PTS points yields one set of sums.

---
 rtl/centroid_accum.sv | 120 ++++++++++++
 tb/tb_centroid_accum.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_accum.sv
// centroid_accum: multiply-accumulates weighted points (x, y, w) over a frame
// and presents sumxw/sumyw/sumw, held stable, to the centroid divider.
module centroid_accum #(
    parameter int N_PTS   = 6,
    parameter int SUMXY_W = 15,
    parameter int SUMW_W  = 7
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         x_in,
    input  logic [7:0]         y_in,
    input  logic [3:0]         w_in,
    output logic [SUMXY_W-1:0] sumxw,
    output logic [SUMXY_W-1:0] sumyw,
    output logic [SUMW_W-1:0]  sumw,
    output logic               zero_w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         pt_cnt
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [2:0] LAST = 3'(N_PTS - 1);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_zero_w;
    logic [2:0]         r_pt_cnt;
    logic [SUMXY_W-1:0] r_sumxw;
    logic [SUMXY_W-1:0] r_sumyw;
    logic [SUMW_W-1:0]  r_sumw;

    logic [11:0]        w_xw;
    logic [11:0]        w_yw;
    logic [SUMXY_W-1:0] w_nxw;
    logic [SUMXY_W-1:0] w_nyw;
    logic [SUMW_W-1:0]  w_nw;
    logic               w_acc;
    logic               w_last;
    logic               w_first;

    assign w_xw    = {4'd0, x_in} * {8'd0, w_in};
    assign w_yw    = {4'd0, y_in} * {8'd0, w_in};
    assign w_first = (r_state == IDLE);

    // The first point of a frame loads the sums instead of adding to them.
    assign w_nxw = (w_first ? '0 : r_sumxw) + SUMXY_W'(w_xw);
    assign w_nyw = (w_first ? '0 : r_sumyw) + SUMXY_W'(w_yw);
    assign w_nw  = (w_first ? '0 : r_sumw) + SUMW_W'(w_in);

    assign w_acc  = in_valid & r_in_ready & ~abort;
    assign w_last = (r_pt_cnt == LAST);

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_zero_w    <= 1'b0;
            r_pt_cnt    <= '0;
            r_sumxw     <= '0;
            r_sumyw     <= '0;
            r_sumw      <= '0;
        end else begin
            unique case (r_state)
                IDLE, ACC: begin
                    r_in_ready <= 1'b1;
                    if (abort) begin
                        r_state  <= IDLE;
                        r_pt_cnt <= '0;
                        r_sumxw  <= '0;
                        r_sumyw  <= '0;
                        r_sumw   <= '0;
                        r_zero_w <= 1'b1;
                    end else if (w_acc) begin
                        r_sumxw  <= w_nxw;
                        r_sumyw  <= w_nyw;
                        r_sumw   <= w_nw;
                        r_zero_w <= (w_nw == '0);
                        if (w_last) begin
                            r_state     <= HOLD;
                            r_pt_cnt    <= '0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state  <= ACC;
                            r_pt_cnt <= r_pt_cnt + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_pt_cnt    <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign zero_w    = r_zero_w;
    assign pt_cnt    = r_pt_cnt;
    assign sumxw     = r_sumxw;
    assign sumyw     = r_sumyw;
    assign sumw      = r_sumw;

endmodule

// File: tb/tb_centroid_accum.sv
// tb_centroid_accum: directed and randomized frames checked against
// plain-arithmetic sums of the accepted points.
module tb_centroid_accum;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  x_in = '0;
    logic [7:0]  y_in = '0;
    logic [3:0]  w_in = '0;
    logic        in_ready;
    logic        zero_w;
    logic        out_valid;
    logic [14:0] sumxw;
    logic [14:0] sumyw;
    logic [6:0]  sumw;
    logic [2:0]  pt_cnt;

    int compared = 0;
    int mismatched = 0;
    int px[N];
    int py[N];
    int pw[N];
    int e_xw = 0;
    int e_yw = 0;
    int e_w = 0;
    int e_cnt = 0;

    always #5 clk = ~clk;

    centroid_accum #(.N_PTS(N), .SUMXY_W(15), .SUMW_W(7)) dut (
        .clk(clk), .RESET(RESET), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .w_in(w_in),
        .sumxw(sumxw), .sumyw(sumyw), .sumw(sumw),
        .zero_w(zero_w), .out_valid(out_valid),
        .out_ready(out_ready), .pt_cnt(pt_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_ir"}, in_ready, 0);
        chk({tag, "_xw"}, sumxw, e_xw);
        chk({tag, "_yw"}, sumyw, e_yw);
        chk({tag, "_w"}, sumw, e_w);
        chk({tag, "_zw"}, zero_w, (e_w == 0));
    endtask

    task automatic send_pt(input int x, input int y, input int w);
        int t = 0;
        in_valid = 1'b1;
        x_in = 8'(x);
        y_in = 8'(y);
        w_in = 4'(w);
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        chk("ready_wait", (t < 20), 1);
        tick();
        in_valid = 1'b0;
        e_xw += x * w;
        e_yw += y * w;
        e_w += w;
        e_cnt = (e_cnt + 1) % N;
        chk("pt_cnt", pt_cnt, e_cnt);
    endtask

    // gaps: 0 none, 1 alternate idle cycles, 2 random idle cycles
    task automatic run_frame(input int gaps, input int hold, input bit ab);
        e_xw = 0;
        e_yw = 0;
        e_w = 0;
        out_ready = (hold == 0);
        for (int i = 0; i < N; i++) begin
            if ((gaps == 1 && i % 2 == 1) ||
                (gaps == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                tick();
                chk("gap_cnt", pt_cnt, e_cnt);
                chk("gap_ov", out_valid, 0);
            end
            send_pt(px[i], py[i], pw[i]);
        end
        chk_outputs("frame");
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            x_in = 8'($urandom_range(0, 255));
            w_in = 4'($urandom_range(1, 15));
            abort = ab;
            tick();
            chk_outputs("stall");
        end
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("done_ov", out_valid, 0);
        chk("done_ir", in_ready, 1);
        chk("kept_xw", sumxw, e_xw);
        chk("kept_w", sumw, e_w);
        out_ready = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < N; i++) begin
            px[i] = 10 * (i + 1);
            py[i] = 5;
            pw[i] = 1;
        end
    endtask

    initial begin
        // Reset behaviour
        #2 RESET = 1'b0;
        #1;
        chk("rst_ir", in_ready, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_xw", sumxw, 0);
        chk("rst_w", sumw, 0);
        chk("rst_cnt", pt_cnt, 0);
        tick();
        chk("rst_ir_clk", in_ready, 0);
        #3 RESET = 1'b1;
        #1 chk("rel_ir", in_ready, 0);
        tick();
        chk("rel_ir_clk", in_ready, 1);

        // Basic frame, out_ready held high
        load_basic();
        run_frame(0, 0, 1'b0);
        chk("basic_xw", e_xw, 210);
        chk("basic_w", e_w, 6);

        // Maximum values
        for (int i = 0; i < N; i++) begin
            px[i] = 255;
            py[i] = 255;
            pw[i] = 15;
        end
        run_frame(0, 0, 1'b0);
        chk("max_xw", e_xw, 22950);

        // Zero weights with 5 cycles of backpressure
        for (int i = 0; i < N; i++) begin
            px[i] = $urandom_range(0, 255);
            py[i] = $urandom_range(0, 255);
            pw[i] = 0;
        end
        run_frame(0, 5, 1'b0);

        // Abort mid-frame, abort beats in_valid
        for (int i = 0; i < 3; i++) send_pt(100, 100, 15);
        in_valid = 1'b1;
        x_in = 8'd100;
        y_in = 8'd100;
        w_in = 4'd15;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        e_cnt = 0;
        chk("abort_cnt", pt_cnt, 0);
        chk("abort_ov", out_valid, 0);
        chk("abort_xw", sumxw, 0);
        chk("abort_w", sumw, 0);
        chk("abort_ir", in_ready, 1);
        load_basic();
        run_frame(0, 0, 1'b0);

        // Asynchronous reset mid-frame
        send_pt(7, 9, 3);
        send_pt(11, 13, 5);
        #3 RESET = 1'b0;
        #1;
        chk("mid_rst_xw", sumxw, 0);
        chk("mid_rst_w", sumw, 0);
        chk("mid_rst_cnt", pt_cnt, 0);
        chk("mid_rst_ir", in_ready, 0);
        #2 RESET = 1'b1;
        e_cnt = 0;
        tick();
        chk("mid_rel_ir", in_ready, 1);
        run_frame(0, 0, 1'b0);

        // Interleaved stalls on in_valid
        run_frame(1, 0, 1'b0);

        // abort in HOLD is ignored
        run_frame(0, 3, 1'b1);

        // Randomized frames, random gaps and backpressure
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) begin
                px[i] = $urandom_range(0, 255);
                py[i] = $urandom_range(0, 255);
                pw[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            end
            run_frame(2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
